piece_lock: RTL and testbench

PIECE_LOCK -- requirements
Module: piece_lock

---
 rtl/tetris_shapes_pkg.sv | 69 ++++++
 rtl/piece_cells.sv | 24 ++
 rtl/tetris_states.vh | 9 +
 rtl/piece_lock.sv | 151 +++++++++++++++
 tb/tb_piece_lock.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_shapes_pkg.sv
// Board geometry, piece footprints (signed cell offsets, row-major, row 0 at the bottom) and line scores.
package tetris_shapes_pkg;

  localparam int COLS        = 10;
  localparam int ROWS        = 20;
  localparam int BOARD_CELLS = COLS * ROWS;

  localparam logic [2:0] BAR      = 3'd0;
  localparam logic [2:0] SQUARE   = 3'd1;
  localparam logic [2:0] T_PIECE  = 3'd2;
  localparam logic [2:0] S_PIECE  = 3'd3;
  localparam logic [2:0] Z_PIECE  = 3'd4;
  localparam logic [2:0] J_PIECE  = 3'd5;
  localparam logic [2:0] L_PIECE  = 3'd6;
  localparam logic [2:0] NO_PIECE = 3'd7;

  typedef logic signed [5:0] offset_t;
  typedef offset_t [3:0] offsets_t;

  function automatic offsets_t ofs4(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  // Offset = drow*COLS + dcol relative to the pivot cell; same footprints as the drop/collision logic.
  function automatic offsets_t shape_offsets(input logic [2:0] block_type, input logic [1:0] rotation);
    case (block_type)
      BAR:     return rotation[0] ? ofs4(-10, 0, 10, 20) : ofs4(-1, 0, 1, 2);
      SQUARE:  return ofs4(0, 1, 10, 11);
      T_PIECE: case (rotation)
                 2'd0:    return ofs4(-1, 0, 1, 10);
                 2'd1:    return ofs4(10, 0, -10, 1);
                 2'd2:    return ofs4(-1, 0, 1, -10);
                 default: return ofs4(10, 0, -10, -1);
               endcase
      S_PIECE: return rotation[0] ? ofs4(10, 0, 1, -9) : ofs4(-1, 0, 10, 11);
      Z_PIECE: return rotation[0] ? ofs4(11, 1, 0, -10) : ofs4(9, 10, 0, 1);
      J_PIECE: case (rotation)
                 2'd0:    return ofs4(9, -1, 0, 1);
                 2'd1:    return ofs4(11, 10, 0, -10);
                 2'd2:    return ofs4(-1, 0, 1, -9);
                 default: return ofs4(10, 0, -10, -11);
               endcase
      L_PIECE: case (rotation)
                 2'd0:    return ofs4(-1, 0, 1, 11);
                 2'd1:    return ofs4(10, 0, -10, -9);
                 2'd2:    return ofs4(-11, -1, 0, 1);
                 default: return ofs4(9, 10, 0, -10);
               endcase
      default: return ofs4(0, 0, 0, 0);
    endcase
  endfunction

  function automatic logic [15:0] line_score(input logic [2:0] lines);
    case (lines)
      3'd1:    return 16'd100;
      3'd2:    return 16'd300;
      3'd3:    return 16'd500;
      3'd4:    return 16'd800;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] add_score(input logic [15:0] score, input logic [2:0] lines);
    logic [16:0] sum;
    sum = {1'b0, score} + {1'b0, line_score(lines)};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/piece_cells.sv
// Maps a pivot location plus shape/rotation to four board cell indices; off-board cells are flagged invalid.
module piece_cells import tetris_shapes_pkg::*; (
  input  logic [7:0]      location,
  input  logic [2:0]      block_type,
  input  logic [1:0]      rotation,
  output logic [3:0][7:0] cells,
  output logic [3:0]      valid
);

  offsets_t offsets;
  assign offsets = shape_offsets(block_type, rotation);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_cell
    logic signed [5:0] offset;
    logic signed [9:0] index;
    assign offset    = offsets[gi];
    // Signed sum so indices below zero stay distinguishable instead of wrapping
    assign index     = $signed({2'b00, location}) + {{4{offset[5]}}, offset};
    assign cells[gi] = index[7:0];
    assign valid[gi] = !index[9] && (index < 10'(BOARD_CELLS)) && (block_type != NO_PIECE);
  end

endmodule

// File: rtl/tetris_states.vh
// Global game FSM state encodings shared by the game controller and its sub-blocks.
`ifndef TETRIS_STATES_VH
`define TETRIS_STATES_VH
`define START      3'd0
`define NEW_BLOCK  3'd1
`define FALLING    3'd2
`define COLLISION  3'd3
`define GAME_OVER  3'd4
`endif

// File: rtl/piece_lock.sv
// Locks a landed piece into the board, clears full rows and reports the next game state.
// Optional line scoring is enabled by defining TETRIS_SCORE_EN.
`include "tetris_states.vh"
module piece_lock import tetris_shapes_pkg::*; #(
  parameter int TOPOUT_ROW = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   game_current_state,
  input  logic [7:0]   location,
  input  logic [2:0]   current_block_type,
  input  logic [1:0]   current_block_rotation,
  input  logic         new_game,
  output logic [199:0] blocks_exist,
  output logic         done_lock,
  output logic [2:0]   game_next_state_lock,
  output logic [2:0]   lines_cleared,
  output logic [15:0]  score
);

  typedef enum logic [2:0] {S_IDLE, S_MERGE, S_SCAN, S_SHIFT, S_DONE} lock_state_t;
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  lock_state_t state_reg;
  logic [4:0]  scan_row_reg;
  logic [7:0]  location_reg;
  logic [2:0]  type_reg;
  logic [1:0]  rotation_reg;
  logic        prev_collision_reg;

  logic             in_collision;
  logic [3:0][7:0]  cell_idx;
  logic [3:0]       cell_valid;
  logic [199:0]     merge_mask;
  logic [199:0]     board_shift;
  logic [ROWS-1:0]  row_full;
  logic [ROWS-1:0]  shift_full;
  logic             cur_row_full;
  logic             topout;
  logic [2:0]       lines_inc;

  assign in_collision = (game_current_state == `COLLISION);

  piece_cells u_cells (
    .location   (location_reg),
    .block_type (type_reg),
    .rotation   (rotation_reg),
    .cells      (cell_idx),
    .valid      (cell_valid)
  );

  always_comb begin
    merge_mask = '0;
    for (int k = 0; k < 4; k++) begin
      if (cell_valid[k]) merge_mask[cell_idx[k]] = 1'b1;
    end
  end

  // board_shift drops every row at or above scan_row by one and empties the top row
  genvar gi;
  for (gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_full[gi] = &blocks_exist[gi*COLS +: COLS];
    if (gi == ROWS - 1) begin : g_top
      assign board_shift[gi*COLS +: COLS] = '0;
    end else begin : g_body
      assign board_shift[gi*COLS +: COLS] = (5'(gi) >= scan_row_reg) ?
          blocks_exist[(gi+1)*COLS +: COLS] : blocks_exist[gi*COLS +: COLS];
    end
    assign shift_full[gi] = &board_shift[gi*COLS +: COLS];
  end

  // A shift cycle also re-tests row r on the data it is moving in, so no separate rescan is spent
  assign cur_row_full = (state_reg == S_SHIFT) ? shift_full[scan_row_reg] : row_full[scan_row_reg];
  assign topout = (state_reg == S_SHIFT) ? |board_shift[TOPOUT_ROW*COLS +: COLS]
                                         : |blocks_exist[TOPOUT_ROW*COLS +: COLS];
  assign lines_inc = (lines_cleared >= 3'd4) ? 3'd4 : lines_cleared + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n || new_game) begin
      state_reg            <= S_IDLE;
      scan_row_reg         <= '0;
      location_reg         <= '0;
      type_reg             <= '0;
      rotation_reg         <= '0;
      prev_collision_reg   <= 1'b1;
      blocks_exist         <= '0;
      done_lock            <= 1'b0;
      game_next_state_lock <= `COLLISION;
      lines_cleared        <= '0;
    end else begin
      prev_collision_reg <= in_collision;
      if (state_reg == S_IDLE) begin
        if (in_collision && !prev_collision_reg) begin
          location_reg  <= location;
          type_reg      <= current_block_type;
          rotation_reg  <= current_block_rotation;
          lines_cleared <= '0;
          state_reg     <= S_MERGE;
        end
      end else if (!in_collision) begin
        state_reg            <= S_IDLE;
        done_lock            <= 1'b0;
        game_next_state_lock <= `COLLISION;
      end else begin
        case (state_reg)
          S_MERGE: begin
            blocks_exist <= blocks_exist | merge_mask;
            scan_row_reg <= '0;
            state_reg    <= S_SCAN;
          end
          S_SCAN, S_SHIFT: begin
            if (state_reg == S_SHIFT) begin
              blocks_exist  <= board_shift;
              lines_cleared <= lines_inc;
            end
            if (cur_row_full) begin
              state_reg <= S_SHIFT;
            end else if (scan_row_reg == LAST_ROW) begin
              state_reg            <= S_DONE;
              done_lock            <= 1'b1;
              game_next_state_lock <= topout ? `GAME_OVER : `NEW_BLOCK;
            end else begin
              scan_row_reg <= scan_row_reg + 5'd1;
              state_reg    <= S_SCAN;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TETRIS_SCORE_EN
  logic        enter_done;
  logic [2:0]  final_lines;
  logic [15:0] score_reg;

  assign enter_done  = in_collision && (state_reg == S_SCAN || state_reg == S_SHIFT) &&
                       !cur_row_full && (scan_row_reg == LAST_ROW);
  assign final_lines = (state_reg == S_SHIFT) ? lines_inc : lines_cleared;

  always_ff @(posedge clk) begin
    if (!rst_n || new_game) score_reg <= '0;
    else if (enter_done)    score_reg <= add_score(score_reg, final_lines);
  end
  assign score = score_reg;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_piece_lock.sv
// Directed bench for piece_lock: table of lock transactions plus reset/new_game/abort sequences.
module tb_piece_lock;

  localparam logic [2:0] ST_NEW_BLOCK = 3'd1;
  localparam logic [2:0] ST_FALLING   = 3'd2;
  localparam logic [2:0] ST_COLLISION = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;
  localparam logic [2:0] T_BAR = 3'd0, T_SQ = 3'd1, T_T = 3'd2, T_J = 3'd5, T_L = 3'd6;
`ifdef TETRIS_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   game_state;
  logic [7:0]   location;
  logic [2:0]   block_type;
  logic [1:0]   block_rot;
  logic         new_game;
  logic [199:0] blocks_exist;
  logic         done_lock;
  logic [2:0]   next_state;
  logic [2:0]   lines_cleared;
  logic [15:0]  score;

  int checks = 0;
  int fails  = 0;

  piece_lock dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .game_current_state     (game_state),
    .location               (location),
    .current_block_type     (block_type),
    .current_block_rotation (block_rot),
    .new_game               (new_game),
    .blocks_exist           (blocks_exist),
    .done_lock              (done_lock),
    .game_next_state_lock   (next_state),
    .lines_cleared          (lines_cleared),
    .score                  (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           ng;
    logic [2:0]   typ;
    logic [1:0]   rot;
    logic [7:0]   loc;
    int           lat;
    logic [2:0]   lines;
    logic [2:0]   nxt;
    bit           chk;
    logic [199:0] board;
    logic [15:0]  score;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(bit ng, logic [2:0] typ, logic [1:0] rot, int loc, int lat,
                              int lines, logic [2:0] nxt, bit chk, logic [199:0] board, int sc);
    vec_t v;
    v.ng = ng; v.typ = typ; v.rot = rot; v.loc = 8'(loc); v.lat = lat;
    v.lines = 3'(lines); v.nxt = nxt; v.chk = chk; v.board = board; v.score = 16'(sc);
    return v;
  endfunction

  function automatic logic [199:0] bits4(logic [199:0] b, int a, int c, int d, int e);
    logic [199:0] r;
    r = b;
    if (a >= 0) r[a] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    if (e >= 0) r[e] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [199:0] exp_board, input logic [15:0] exp_score);
    check({tag, " board"}, blocks_exist, exp_board);
    check({tag, " done"}, done_lock, 1'b0);
    check({tag, " next"}, next_state, ST_COLLISION);
    check({tag, " lines"}, lines_cleared, 3'd0);
    check({tag, " score"}, score, exp_score);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check_idle_outputs("new_game", '0, 16'd0);
    @(negedge clk);
  endtask

  task automatic start_lock(input logic [2:0] typ, input logic [1:0] rot, input int loc);
    block_type = typ; block_rot = rot; location = 8'(loc);
    game_state = ST_COLLISION;
  endtask

  task automatic hold_no_restart(input string tag);
    bit seen;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done_lock) seen = 1'b1;
    end
    check({tag, " no restart"}, seen, 1'b0);
    game_state = ST_FALLING;
    @(negedge clk);
  endtask

  task automatic run_lock(input int idx, input vec_t v);
    int lat;
    bit seen;
    if (v.ng) pulse_new_game();
    start_lock(v.typ, v.rot, v.loc);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (done_lock) begin
        seen = 1'b1;
        lat  = c + 1;
      end
    end
    check($sformatf("v%0d done_seen", idx), seen, 1'b1);
    if (v.lat != 0) check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d lines", idx), lines_cleared, v.lines);
    check($sformatf("v%0d next", idx), next_state, v.nxt);
    if (v.chk) check($sformatf("v%0d board", idx), blocks_exist, v.board);
    check($sformatf("v%0d score", idx), score, SCORE_ON ? v.score : 16'd0);
    $display("lock %0d type=%0d rot=%0d loc=%0d cycle=%0d lines=%0d next=%0d score=%0d",
             idx, v.typ, v.rot, v.loc, lat, lines_cleared, next_state, score);
    game_state = ST_FALLING;
    @(negedge clk);
    check($sformatf("v%0d release done", idx), done_lock, 1'b0);
    check($sformatf("v%0d release next", idx), next_state, ST_COLLISION);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [199:0] b3, b16, b17, b18, rows4;
    rows4 = '0;
    for (int r = 0; r < 4; r++) rows4 = rows4 | (200'h1FF << (10 * r));
    b3  = bits4(bits4(bits4('0, 0, 1, 2, 3), 4, 5, 14, 15), 8, 9, 18, 19);
    b16 = bits4('0, 185, 195, -1, -1);
    b17 = bits4(b16, 51, 52, 53, 62);
    b18 = bits4(b17, 72, 82, 83, 84);

    vecs[0]  = mk(1, T_SQ,  0, 0,   23, 0, ST_NEW_BLOCK, 1, bits4('0, 0, 1, 10, 11), 0);
    vecs[1]  = mk(1, T_BAR, 0, 1,   23, 0, ST_NEW_BLOCK, 1, bits4('0, 0, 1, 2, 3), 0);
    vecs[2]  = mk(0, T_SQ,  0, 4,   23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[3]  = mk(0, T_SQ,  0, 8,   23, 0, ST_NEW_BLOCK, 1, b3, 0);
    vecs[4]  = mk(0, T_BAR, 0, 7,   24, 1, ST_NEW_BLOCK, 1, bits4('0, 4, 5, 8, 9), 100);
    vecs[5]  = mk(0, T_BAR, 1, 0,   23, 0, ST_NEW_BLOCK, 1, bits4(bits4('0, 4, 5, 8, 9), 0, 10, 20, -1), 100);
    vecs[6]  = mk(1, T_BAR, 0, 1,   23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[7]  = mk(0, T_BAR, 0, 5,   23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[8]  = mk(0, T_BAR, 0, 11,  23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[9]  = mk(0, T_BAR, 0, 15,  23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[10] = mk(0, T_BAR, 0, 21,  23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[11] = mk(0, T_BAR, 0, 25,  23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[12] = mk(0, T_BAR, 0, 31,  23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[13] = mk(0, T_BAR, 0, 35,  23, 0, ST_NEW_BLOCK, 0, '0, 0);
    vecs[14] = mk(0, T_BAR, 1, 18,  23, 0, ST_NEW_BLOCK, 1, rows4, 0);
    vecs[15] = mk(0, T_BAR, 1, 19,  27, 4, ST_NEW_BLOCK, 1, '0, 800);
    vecs[16] = mk(0, T_BAR, 1, 195, 23, 0, ST_GAME_OVER, 1, b16, 800);
    vecs[17] = mk(0, T_T,   0, 52,  23, 0, ST_GAME_OVER, 1, b17, 800);
    vecs[18] = mk(0, T_L,   2, 83,  23, 0, ST_GAME_OVER, 1, b18, 800);
    vecs[19] = mk(0, T_J,   1, 100, 23, 0, ST_GAME_OVER, 1, bits4(b18, 111, 110, 100, 90), 800);

    rst_n = 1'b0; new_game = 1'b0; game_state = ST_FALLING;
    location = '0; block_type = '0; block_rot = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset", '0, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) run_lock(i, vecs[i]);

    // Synchronous reset while scanning: progress is discarded, held COLLISION must not restart
    pulse_new_game();
    start_lock(T_SQ, 0, 0);
    repeat (5) @(negedge clk);
    check("h1 mid done", done_lock, 1'b0);
    check("h1 mid next", next_state, ST_COLLISION);
    check("h1 mid board", blocks_exist, bits4('0, 0, 1, 10, 11));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("h1 reset", '0, 16'd0);
    hold_no_restart("h1");
    run_lock(100, mk(0, T_SQ, 0, 0, 23, 0, ST_NEW_BLOCK, 1, bits4('0, 0, 1, 10, 11), 0));

    // new_game while scanning
    start_lock(T_BAR, 0, 21);
    repeat (5) @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check_idle_outputs("h2 new_game", '0, 16'd0);
    hold_no_restart("h2");

    // COLLISION drops mid-operation: abort but keep merged cells
    start_lock(T_SQ, 0, 0);
    repeat (4) @(negedge clk);
    game_state = ST_FALLING;
    @(negedge clk);
    check_idle_outputs("h3 abort", bits4('0, 0, 1, 10, 11), 16'd0);
    @(negedge clk);
    run_lock(101, mk(0, T_SQ, 0, 2, 23, 0, ST_NEW_BLOCK, 1,
                     bits4(bits4('0, 0, 1, 10, 11), 2, 3, 12, 13), 0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
